// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin WISHBONE master arbiter with a bus watchdog.
// Define WB_ARB_STATS_EN to add saturating timeout and per-master grant counters.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] cyc_i,
    input  logic                   stb_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   to_err_o,
    output logic                   timeout_o,
    output logic                   busy_o
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]               timeout_count_o,
    output logic [NUM_MASTERS*16-1:0] grant_count_o
`endif
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST =
        CNT_WIDTH'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TOUT
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic                   to_err_q, to_err_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_vld;
    logic             term;
    logic             stall;
    logic             owner_cyc;

    // last_q doubles as the index of the current owner while a grant is held.
    assign term      = ack_i | err_i | rty_i;
    assign stall     = stb_i & ~term;
    assign owner_cyc = cyc_i[last_q];

    // Rotating search: first requester after the most recent grantee.
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_MASTERS);
            if (!pick_vld && cyc_i[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Grant/watchdog state machine; termination beats watchdog expiry.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        wd_cnt_d  = '0;
        to_err_d  = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_GRANT;
                    gnt_d   = NUM_MASTERS'(1) << pick;
                    last_d  = pick;
                end
            end
            S_GRANT: begin
                if (!owner_cyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (stall) begin
                    if (WD_EN && wd_cnt_q == WD_LAST) begin
                        state_d   = S_TOUT;
                        to_err_d  = 1'b1;
                        timeout_d = 1'b1;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        wd_cnt_d = wd_cnt_q;
                    end
                end
            end
            S_TOUT: begin
                if (!owner_cyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = |gnt_d;
    end

    // Registered state and outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            to_err_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= LAST_RST;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            to_err_q  <= to_err_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign to_err_o  = to_err_q;
    assign timeout_o = timeout_q;
    assign busy_o    = busy_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0]               tcnt_q, tcnt_d;
    logic [NUM_MASTERS*16-1:0] gcnt_q, gcnt_d;

    // Saturating counts of watchdog firings and of new grants per master.
    always_comb begin
        tcnt_d = tcnt_q;
        gcnt_d = gcnt_q;
        if (timeout_d && tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
        end
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (state_q == S_IDLE && pick_vld && pick == IDX_W'(m)
                && gcnt_q[16*m +: 16] != 16'hFFFF) begin
                gcnt_d[16*m +: 16] = gcnt_q[16*m +: 16] + 16'd1;
            end
        end
    end

    // Statistics registers, cleared with the arbiter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
            gcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign timeout_count_o = tcnt_q;
    assign grant_count_o   = gcnt_q;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_wb_rr_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] cyc = '0;
    logic stb = 1'b0;
    logic ack = 1'b0;
    logic err = 1'b0;
    logic rty = 1'b0;

    logic [N-1:0] gnt, gnt0;
    logic to_err, timeout, busy;
    logic to_err0, timeout0, busy0;
`ifdef WB_ARB_STATS_EN
    logic [15:0]     tcount, tcount0;
    logic [N*16-1:0] gcount, gcount0;
`endif

    int n_pass = 0;
    int n_total = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .TIMEOUT_CYCLES(T), .CNT_WIDTH(16)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb),
        .ack_i(ack), .err_i(err), .rty_i(rty),
        .gnt_o(gnt), .to_err_o(to_err), .timeout_o(timeout), .busy_o(busy)
`ifdef WB_ARB_STATS_EN
        , .timeout_count_o(tcount), .grant_count_o(gcount)
`endif
    );

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .TIMEOUT_CYCLES(0), .CNT_WIDTH(16)
    ) u_dut_nowd (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb),
        .ack_i(ack), .err_i(err), .rty_i(rty),
        .gnt_o(gnt0), .to_err_o(to_err0), .timeout_o(timeout0), .busy_o(busy0)
`ifdef WB_ARB_STATS_EN
        , .timeout_count_o(tcount0), .grant_count_o(gcount0)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    int       m_owner;
    int       m_last;
    int       m_stall;
    bit       m_expired;
    logic [N-1:0] exp_gnt;
    logic     exp_to;
    int       m_tcnt;
    int       m_gcnt [N];
    int       m_pick;

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always_comb m_pick = rr_pick(m_last, cyc);

    always @(posedge clk) begin
        if (rst) begin
            m_owner   <= -1;
            m_last    <= N - 1;
            m_stall   <= 0;
            m_expired <= 1'b0;
            exp_gnt   <= '0;
            exp_to    <= 1'b0;
            m_tcnt    <= 0;
            for (int i = 0; i < N; i++) m_gcnt[i] <= 0;
        end else if (m_owner < 0) begin
            exp_to <= 1'b0;
            if (m_pick >= 0) begin
                m_owner <= m_pick;
                m_last  <= m_pick;
                exp_gnt <= N'(1) << m_pick;
                m_stall <= 0;
                m_gcnt[m_pick] <= (m_gcnt[m_pick] < 65535) ? m_gcnt[m_pick] + 1 : 65535;
            end
        end else if (!cyc[m_owner]) begin
            m_owner   <= -1;
            exp_gnt   <= '0;
            exp_to    <= 1'b0;
            m_stall   <= 0;
            m_expired <= 1'b0;
        end else if (m_expired) begin
            exp_to <= 1'b0;
        end else if (stb && !(ack || err || rty)) begin
            if (m_stall + 1 == T) begin
                exp_to    <= 1'b1;
                m_expired <= 1'b1;
                m_stall   <= 0;
                m_tcnt    <= (m_tcnt < 65535) ? m_tcnt + 1 : 65535;
            end else begin
                exp_to  <= 1'b0;
                m_stall <= m_stall + 1;
            end
        end else begin
            exp_to  <= 1'b0;
            m_stall <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("gnt", gnt, exp_gnt);
            chk("to_err", to_err, exp_to);
            chk("timeout", timeout, exp_to);
            chk("busy", busy, |exp_gnt);
            chk("nowd_gnt", gnt0, exp_gnt);
            chk("nowd_to_err", to_err0, 1'b0);
            chk("nowd_timeout", timeout0, 1'b0);
`ifdef WB_ARB_STATS_EN
            chk("timeout_count", tcount, m_tcnt);
            for (int i = 0; i < N; i++) chk("grant_count", gcount[16*i +: 16], m_gcnt[i]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset values, single request and release
        nxt();
        mon_en = 1'b1;
        nxt();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_to_err", to_err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0;
        cyc = 4'b0100;
        nxt();
        chk("t1_gnt", gnt, 4'b0100);
        chk("t1_busy", busy, 1'b1);
        cyc = 4'b0000;
        nxt();
        chk("t1_drop_gnt", gnt, 4'b0000);
        chk("t1_drop_busy", busy, 1'b0);

        // 2: rotation with all requesting
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        stb = 1'b1;
        cyc = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] one;
            one = 4'(1) << (k % 4);
            nxt();
            chk("t2_gnt", gnt, one);
            ack = 1'b1;
            nxt();
            chk("t2_hold", gnt, one);
            ack = 1'b0;
            cyc = 4'b1111 & ~one;
            nxt();
            chk("t2_idle", gnt, 4'b0000);
            cyc = 4'b1111;
        end
        cyc = 4'b0000;
        stb = 1'b0;
        nxt();

        // 3: watchdog fires 8 cycles after stb
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        cyc = 4'b0010;
        nxt();
        chk("t3_gnt", gnt, 4'b0010);
        stb = 1'b1;
        for (int i = 0; i < 7; i++) begin
            nxt();
            chk("t3_quiet", to_err, 1'b0);
        end
        nxt();
        chk("t3_to_err", to_err, 1'b1);
        chk("t3_timeout", timeout, 1'b1);
        chk("t3_gnt_held", gnt, 4'b0010);
        nxt();
        chk("t3_to_err_pulse", to_err, 1'b0);
        chk("t3_gnt_held2", gnt, 4'b0010);
        ack = 1'b1;
        nxt();
        chk("t3_late_ack", to_err, 1'b0);
        ack = 1'b0;
        cyc = 4'b0000;
        stb = 1'b0;
        nxt();
        chk("t3_release", gnt, 4'b0000);

        // 4: ack on the 8th stalled cycle wins; late ack in timeout ignored
        cyc = 4'b0010;
        nxt();
        chk("t4_gnt", gnt, 4'b0010);
        stb = 1'b1;
        repeat (7) nxt();
        ack = 1'b1;
        nxt();
        chk("t4_ack_wins", to_err, 1'b0);
        ack = 1'b0;
        repeat (7) nxt();
        chk("t4_not_yet", to_err, 1'b0);
        nxt();
        chk("t4_fire", to_err, 1'b1);
        ack = 1'b1;
        nxt();
        chk("t4_late_ack", to_err, 1'b0);
        ack = 1'b0;
        repeat (3) begin
            nxt();
            chk("t4_no_repeat", to_err, 1'b0);
        end
        cyc = 4'b0000;
        stb = 1'b0;
        nxt();

        // 5: no switch mid-cyc; reset mid-transfer restores last
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        cyc = 4'b0001;
        nxt();
        chk("t5_gnt", gnt, 4'b0001);
        cyc = 4'b1001;
        nxt();
        chk("t5_hold", gnt, 4'b0001);
        nxt();
        chk("t5_hold2", gnt, 4'b0001);
        rst = 1'b1;
        cyc = 4'b1111;
        nxt();
        chk("t5_rst_gnt", gnt, 4'b0000);
        rst = 1'b0;
        nxt();
        chk("t5_after_rst", gnt, 4'b0001);
        cyc = 4'b0000;
        nxt();

`ifdef WB_ARB_STATS_EN
        // 6: statistics
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc = 4'b0100;
            stb = (k < 3);
            nxt();
            if (k < 3) repeat (9) nxt();
            cyc = 4'b0000;
            stb = 1'b0;
            nxt();
        end
        chk("t6_timeouts", tcount, 16'd3);
        chk("t6_grants2", gcount[47:32], 16'd5);
`endif

        // random traffic
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!cyc[i]) cyc[i] = ($urandom_range(3) == 0);
                else if ($urandom_range(15) == 0) cyc[i] = 1'b0;
            end
            stb = ($urandom_range(3) != 0);
            ack = ($urandom_range(7) == 0);
            err = ($urandom_range(31) == 0);
            rty = ($urandom_range(31) == 0);
            rst = ($urandom_range(299) == 0);
            nxt();
        end
        rst = 1'b0;
        cyc = '0;
        nxt();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
